// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS sequencing controller:
//   - opcode / funct field values of the supported instruction subset
//   - 4-bit ALU control codes driven to the datapath ALU
//   - controller state encoding (4-bit, codes 12..15 unused)
//   - ALU operand-B and PC-source mux encodings
//   - alu_op selector used between the FSM and the ALU decoder
// ---------------------------------------------------------------------------
package mips_pkg;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU operand-B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // How the ALU decoder should pick the ALU operation
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } alu_op_t;

    // andi/ori take a zero-extended immediate; everything else sign-extends
    function automatic logic imm_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational map from the FSM's alu_op request to the 4-bit ALU control.
//   i_alu_op        add / sub / use funct / use immediate opcode
//   i_funct         R-type funct field
//   i_op            opcode (selects the immediate-class operation)
//   o_alu_control   ALU operation code
//   o_illegal_funct funct not supported (meaningful only for ALUOP_FUNCT)
// ---------------------------------------------------------------------------
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [5:0] i_funct,
    input  logic [5:0] i_op,
    output logic [3:0] o_alu_control,
    output logic       o_illegal_funct
);

    always_comb begin
        o_alu_control   = ALU_ADD;
        o_illegal_funct = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    FN_NOR:  o_alu_control = ALU_NOR;
                    default: o_illegal_funct = 1'b1;
                endcase
            end
            ALUOP_IMM: begin
                case (i_op)
                    OP_ANDI: o_alu_control = ALU_AND;
                    OP_ORI:  o_alu_control = ALU_OR;
                    OP_SLTI: o_alu_control = ALU_SLT;
                    default: o_alu_control = ALU_ADD;  // addi
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore sequencing controller for the shared-memory multi-cycle MIPS core.
// One micro-step per clock; stalls in FETCH/MEMRD/MEMWR until mem_ready and
// counts retired instructions.
//   clk, rst        clock, synchronous active-low reset
//   op, funct       instruction fields from the instruction register
//   zero            ALU zero flag (branch qualification)
//   mem_ready       memory finished the current access this cycle
//   mem_req/iord/mem_write/ir_write/pc_en      memory and PC strobes
//   reg_dst/mem_to_reg/reg_write               register-file write-back
//   alu_src_a/alu_src_b/ext_zero/alu_control   ALU operand/operation select
//   pc_src          next-PC source
//   illegal         one-cycle pulse on unsupported opcode/funct
//   instr_count     retired-instruction counter, wraps silently
// ---------------------------------------------------------------------------
module multicycle_control
    import mips_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_en,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [1:0]         pc_src,
    output logic [3:0]         alu_control,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    state_t               r_state;
    state_t               w_next;
    logic [COUNT_W-1:0]   r_count;
    logic                 w_retire;
    alu_op_t              w_alu_op;
    logic                 w_illegal_funct;

    // Raw decoded strobes before the reset override
    logic w_mem_req, w_mem_write, w_ir_write, w_pc_en, w_reg_write, w_illegal;

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct         (funct),
        .i_op            (op),
        .o_alu_control   (alu_control),
        .o_illegal_funct (w_illegal_funct)
    );

    // State register and retirement counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + COUNT_W'(1);
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_alu_op    = ALUOP_ADD;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_en     = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        ext_zero    = 1'b0;
        pc_src      = PCSRC_ALU;

        case (r_state)
            S_FETCH: begin
                // ALU computes PC+4 every cycle; only latch it on completion
                w_mem_req = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_en    = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut
                alu_src_b = SRCB_BROFF;
                case (op)
                    OP_LW, OP_SW:                     w_next = S_MEMADR;
                    OP_RTYPE:                         w_next = S_EXEC;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IMMEXEC;
                    OP_J:                             w_next = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe held for the whole wait; memory commits on ready
                w_mem_req   = 1'b1;
                iord        = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
                if (w_illegal_funct) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_next    = S_ALUWB;
                end
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                w_pc_en   = (op == OP_BNE) ? ~zero : zero;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_IMMEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_IMM;
                ext_zero  = imm_zero_ext(op);
                w_next    = S_IMMWB;
            end
            S_IMMWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                w_pc_en  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // While in reset the side-effecting strobes are held low regardless of state
    assign mem_req     = rst & w_mem_req;
    assign mem_write   = rst & w_mem_write;
    assign ir_write    = rst & w_ir_write;
    assign pc_en       = rst & w_pc_en;
    assign reg_write   = rst & w_reg_write;
    assign illegal     = rst & w_illegal;
    assign instr_count = r_count;

endmodule
